// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings and the pipelined control word for pipe_ctrl_unit.
// dest is carried at DEST_W bits so any RA_W up to DEST_W fits without re-typing the struct.
package pipe_ctrl_pkg;
  localparam int DEST_W = 16;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_JR  = 2'b01;
  localparam logic [1:0] PC_BEQ = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  typedef struct packed {
    logic [3:0]        alu_op;
    logic              alu_src;
    logic [1:0]        pcsrc;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              memtoreg;
    logic [DEST_W-1:0] dest;
    logic              illegal;
  } ctrl_t;
  localparam ctrl_t CW_ILLEGAL = '{illegal: 1'b1, default: '0};
  // reg_write is never set with dest 0, so this also rejects $0
  function automatic logic writes(input ctrl_t c, input logic [DEST_W-1:0] r);
    return c.reg_write && c.dest == r;
  endfunction
endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: combinational ID-stage decode of opcode/funct into a control word.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [5:0]      i_opcode,
  input  logic [5:0]      i_funct,
  input  logic [RA_W-1:0] i_rt,
  input  logic [RA_W-1:0] i_rd,
  output ctrl_t           o_ctrl
);
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest = DEST_W'(i_rd);
        case (i_funct)
          FN_ADD, FN_ADDU: o_ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: o_ctrl.alu_op = ALU_SUB;
          FN_AND: o_ctrl.alu_op = ALU_AND;
          FN_OR:  o_ctrl.alu_op = ALU_OR;
          FN_NOR: o_ctrl.alu_op = ALU_NOR;
          FN_SLT: o_ctrl.alu_op = ALU_SLT;
          FN_SLL: o_ctrl.alu_op = ALU_SLL;
          FN_SRL: o_ctrl.alu_op = ALU_SRL;
          FN_SRA: o_ctrl.alu_op = ALU_SRA;
          FN_JR: begin
            o_ctrl.reg_write = 1'b0;
            o_ctrl.dest = '0;
            o_ctrl.pcsrc = PC_JR;
          end
          default: o_ctrl = CW_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest = DEST_W'(i_rt);
      end
      OP_LW: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.mem_read = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest = DEST_W'(i_rt);
      end
      OP_SW: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.pcsrc = PC_BEQ;
      end
      OP_J: o_ctrl.pcsrc = PC_J;
      default: o_ctrl = CW_ILLEGAL;
    endcase
    if (o_ctrl.dest == '0) o_ctrl.reg_write = 1'b0;
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control with load-use/RAW stalls, branch flush and optional forwarding.
// Define PIPE_CTRL_FWD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards fully interlock.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int RA_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               br_taken,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic [1:0]         ex_pcsrc,
  output logic [RA_W-1:0]    ex_rs,
  output logic [RA_W-1:0]    ex_rt,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_memtoreg,
  output logic [RA_W-1:0]    wb_dest,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               stall,
  output logic               illegal,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);
  ctrl_t w_dec, r_idex, r_exmem, r_memwb;
  logic [RA_W-1:0] r_ex_rs, r_ex_rt;
  logic [DEST_W-1:0] w_rs, w_rt;
  logic w_load_use, w_raw, w_stall, w_bubble, w_unused;
  pipe_ctrl_decode #(.RA_W(RA_W)) u_decode (
    .i_opcode(opcode),
    .i_funct (funct),
    .i_rt    (id_rt),
    .i_rd    (id_rd),
    .o_ctrl  (w_dec)
  );
  assign w_rs = DEST_W'(id_rs);
  assign w_rt = DEST_W'(id_rt);
  assign w_load_use = r_idex.mem_read && r_idex.dest != '0 &&
                      (r_idex.dest == w_rs || r_idex.dest == w_rt);
`ifdef PIPE_CTRL_FWD_EN
  logic [DEST_W-1:0] w_ex_rs, w_ex_rt;
  assign w_ex_rs = DEST_W'(r_ex_rs);
  assign w_ex_rt = DEST_W'(r_ex_rt);
  assign w_raw = 1'b0;
  assign fwd_a = writes(r_exmem, w_ex_rs) ? FWD_MEM : writes(r_memwb, w_ex_rs) ? FWD_WB : FWD_NONE;
  assign fwd_b = writes(r_exmem, w_ex_rt) ? FWD_MEM : writes(r_memwb, w_ex_rt) ? FWD_WB : FWD_NONE;
`else
  // MEM/WB needs no check: the register file writes in the first half-cycle
  assign w_raw = writes(r_idex, w_rs) || writes(r_exmem, w_rs) ||
                 writes(r_idex, w_rt) || writes(r_exmem, w_rt);
  assign fwd_a = FWD_NONE;
  assign fwd_b = FWD_NONE;
`endif
  assign w_stall = (w_load_use || w_raw) && !br_taken;
  assign w_bubble = w_stall || br_taken;
  assign stall = w_stall;
  assign pc_write = !w_stall;
  assign ifid_write = !w_stall;
  assign ifid_flush = br_taken;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
      r_ex_rs <= '0;
      r_ex_rt <= '0;
    end else begin
      r_idex <= w_bubble ? '0 : w_dec;
      r_ex_rs <= w_bubble ? '0 : id_rs;
      r_ex_rt <= w_bubble ? '0 : id_rt;
      r_exmem <= r_idex;
      r_memwb <= r_exmem;
    end
  end
  assign ex_alu_op = ALUOP_W'(r_idex.alu_op);
  assign ex_alu_src = r_idex.alu_src;
  assign ex_pcsrc = r_idex.pcsrc;
  assign ex_rs = r_ex_rs;
  assign ex_rt = r_ex_rt;
  assign illegal = r_idex.illegal;
  assign mem_read = r_exmem.mem_read;
  assign mem_write = r_exmem.mem_write;
  assign wb_reg_write = r_memwb.reg_write;
  assign wb_memtoreg = r_memwb.memtoreg;
  assign wb_dest = r_memwb.dest[RA_W-1:0];
  assign w_unused = ^r_memwb;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed self-checking bench for pipe_ctrl_unit (both PIPE_CTRL_FWD_EN builds).
module tb_pipe_ctrl_unit;
  logic clk = 1'b0;
  logic rst, br_taken;
  logic [5:0] opcode, funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [4:0] ex_alu_op, ex_rs, ex_rt, wb_dest;
  logic ex_alu_src, mem_read, mem_write, wb_reg_write, wb_memtoreg;
  logic pc_write, ifid_write, ifid_flush, stall, illegal;
  logic [1:0] ex_pcsrc, fwd_a, fwd_b;
  int checks = 0;
  int errors = 0;
  pipe_ctrl_unit #(.ALUOP_W(5), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken(br_taken),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_pcsrc(ex_pcsrc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .stall(stall), .illegal(illegal), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    opcode = op;
    funct = fn;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    #1;
  endtask
  task automatic nop;
    drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd0);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  logic [5:0] alu_fn [10] = '{6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h03, 6'h2A, 6'h21, 6'h23};
  int alu_code [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1};
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    br_taken = 1'b0;
    nop();
    tick();
    tick();
    chk("rst_alu_op", ex_alu_op, 0);
    chk("rst_alu_src", ex_alu_src, 0);
    chk("rst_pcsrc", ex_pcsrc, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_fwd_a", fwd_a, 0);
    rst = 1'b0;
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
    chk("add_stall", stall, 0);
    tick();
    chk("add_ex_alu_op", ex_alu_op, 0);
    chk("add_ex_rs", ex_rs, 1);
    chk("add_ex_rt", ex_rt, 2);
    nop();
    tick();
    tick();
    chk("add_wb_reg_write", wb_reg_write, 1);
    chk("add_wb_dest", wb_dest, 3);
    for (int i = 0; i < 10; i++) begin
      drive(6'h00, alu_fn[i], 5'd0, 5'd0, 5'd10);
      tick();
      chk($sformatf("alu_fn_%0h", alu_fn[i]), ex_alu_op, alu_code[i]);
    end
    nop();
    tick();
    drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    chk("lw_stall_before", stall, 0);
    tick();
    chk("lw_ex_alu_src", ex_alu_src, 1);
    drive(6'h00, 6'h20, 5'd5, 5'd2, 5'd6);
    chk("lu_stall", stall, 1);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_ifid_flush", ifid_flush, 0);
    tick();
    chk("lu_bubble_rs", ex_rs, 0);
    chk("lu_bubble_alu_src", ex_alu_src, 0);
    chk("lu_mem_read", mem_read, 1);
`ifdef PIPE_CTRL_FWD_EN
    chk("lu_stall_end", stall, 0);
    tick();
    chk("lu_wb_memtoreg", wb_memtoreg, 1);
    chk("lu_wb_dest", wb_dest, 5);
    chk("lu_add_ex_rs", ex_rs, 5);
`else
    chk("lu_stall_2nd", stall, 1);
    tick();
    chk("lu_bubble2_rs", ex_rs, 0);
    chk("lu_wb_memtoreg", wb_memtoreg, 1);
    chk("lu_wb_dest", wb_dest, 5);
    chk("lu_stall_end", stall, 0);
    tick();
    chk("lu_add_ex_rs", ex_rs, 5);
`endif
    nop();
    tick();
    tick();
    tick();
    drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    tick();
    br_taken = 1'b1;
    drive(6'h00, 6'h20, 5'd5, 5'd2, 5'd6);
    chk("fl_stall", stall, 0);
    chk("fl_pc_write", pc_write, 1);
    chk("fl_ifid_write", ifid_write, 1);
    chk("fl_ifid_flush", ifid_flush, 1);
    tick();
    chk("fl_bubble_rs", ex_rs, 0);
    chk("fl_bubble_alu_op", ex_alu_op, 0);
    chk("fl_mem_read", mem_read, 1);
    br_taken = 1'b0;
    nop();
    chk("fl_flush_clear", ifid_flush, 0);
    tick();
    tick();
    tick();
    drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
    tick();
    drive(6'h00, 6'h20, 5'd5, 5'd2, 5'd6);
    chk("rs_stall_pre", stall, 1);
    rst = 1'b1;
    #1;
    chk("rs_stall", stall, 0);
    chk("rs_pc_write", pc_write, 1);
    chk("rs_alu_src", ex_alu_src, 0);
    nop();
    tick();
    rst = 1'b0;
    tick();
    chk("rs_ex_rs", ex_rs, 0);
    chk("rs_stall_after", stall, 0);
    drive(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    tick();
    chk("ill_op", illegal, 1);
    chk("ill_op_alu_op", ex_alu_op, 0);
    chk("ill_op_pcsrc", ex_pcsrc, 0);
    drive(6'h00, 6'h3F, 5'd0, 5'd0, 5'd3);
    tick();
    chk("ill_fn", illegal, 1);
    nop();
    tick();
    chk("ill_clear", illegal, 0);
    tick();
    chk("ill_wb_reg_write", wb_reg_write, 0);
    drive(6'h08, 6'h00, 5'd1, 5'd9, 5'd0);
    tick();
    chk("addi_alu_src", ex_alu_src, 1);
    drive(6'h08, 6'h00, 5'd1, 5'd0, 5'd0);
    tick();
    nop();
    tick();
    chk("addi9_wb_reg_write", wb_reg_write, 1);
    chk("addi9_wb_dest", wb_dest, 9);
    tick();
    chk("addi0_wb_reg_write", wb_reg_write, 0);
    drive(6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
    tick();
    chk("beq_pcsrc", ex_pcsrc, 2);
    chk("beq_alu_op", ex_alu_op, 1);
    drive(6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
    tick();
    chk("j_pcsrc", ex_pcsrc, 3);
    drive(6'h00, 6'h08, 5'd31, 5'd0, 5'd0);
    tick();
    chk("jr_pcsrc", ex_pcsrc, 1);
    drive(6'h2B, 6'h00, 5'd1, 5'd7, 5'd0);
    tick();
    chk("sw_alu_src", ex_alu_src, 1);
    chk("sw_pcsrc", ex_pcsrc, 0);
    nop();
    tick();
    chk("sw_mem_write", mem_write, 1);
    chk("sw_mem_read", mem_read, 0);
    tick();
    chk("sw_mem_write_clear", mem_write, 0);
    chk("jr_wb_reg_write", wb_reg_write, 0);
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd4);
    tick();
    drive(6'h00, 6'h22, 5'd4, 5'd4, 5'd7);
`ifdef PIPE_CTRL_FWD_EN
    chk("raw_stall", stall, 0);
    tick();
    chk("raw_ex_alu_op", ex_alu_op, 1);
    chk("raw_fwd_a", fwd_a, 2);
    chk("raw_fwd_b", fwd_b, 2);
`else
    chk("raw_stall1", stall, 1);
    tick();
    chk("raw_bubble_rs", ex_rs, 0);
    chk("raw_stall2", stall, 1);
    tick();
    chk("raw_stall_end", stall, 0);
    tick();
    chk("raw_ex_alu_op", ex_alu_op, 1);
    chk("raw_ex_rs", ex_rs, 4);
    chk("raw_fwd_a", fwd_a, 0);
    chk("raw_fwd_b", fwd_b, 0);
`endif
    nop();
    tick();
    tick();
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd4);
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd4);
    tick();
    drive(6'h00, 6'h25, 5'd4, 5'd0, 5'd8);
`ifdef PIPE_CTRL_FWD_EN
    chk("pri_stall", stall, 0);
    tick();
    chk("pri_ex_alu_op", ex_alu_op, 3);
    chk("pri_fwd_a", fwd_a, 2);
    chk("pri_fwd_b", fwd_b, 0);
`else
    chk("pri_stall1", stall, 1);
    tick();
    chk("pri_stall2", stall, 1);
    tick();
    chk("pri_stall_end", stall, 0);
    tick();
    chk("pri_ex_alu_op", ex_alu_op, 3);
    chk("pri_fwd_a", fwd_a, 0);
`endif
    nop();
    tick();
    tick();
    tick();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd4);
    tick();
    nop();
    tick();
    drive(6'h00, 6'h25, 5'd4, 5'd0, 5'd8);
`ifdef PIPE_CTRL_FWD_EN
    chk("wbf_stall", stall, 0);
    tick();
    chk("wbf_fwd_a", fwd_a, 1);
`else
    chk("wbf_stall", stall, 1);
    tick();
    chk("wbf_stall_end", stall, 0);
    tick();
    chk("wbf_ex_alu_op", ex_alu_op, 3);
    chk("wbf_fwd_a", fwd_a, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle decode controller.
- Decodes opcode/funct in ID and carries the control word through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and RAW hazards, inserts bubbles, and applies branch/jump flushes.
- Sits between the IF/ID register and the datapath. Drives stage-local control, PC/IF-ID write enables and, optionally, forwarding selects.

Parameters:
- ALUOP_W, 5, ALU opcode width. Must be at least 4; upper bits are zero-filled.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; all registers update on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction [31:26] from IF/ID
- funct  in  6  instruction [5:0] from IF/ID
- id_rs, id_rt, id_rd  in  RA_W each  register fields from IF/ID
- br_taken  in  1  EX-stage branch/jump redirect (flush request)
- ex_alu_op  out  ALUOP_W  ALU operation for EX
- ex_alu_src  out  1  1 = immediate operand
- ex_pcsrc  out  2  00 seq, 01 jr, 10 beq, 11 j
- ex_rs, ex_rt  out  RA_W each  ID/EX source registers
- mem_read, mem_write  out  1 each  data-memory control in MEM
- wb_reg_write, wb_memtoreg  out  1 each  WB control
- wb_dest  out  RA_W  WB destination register
- pc_write, ifid_write  out  1 each  0 = hold PC / IF-ID
- ifid_flush  out  1  clear IF/ID
- stall  out  1  hazard stall this cycle
- illegal  out  1  registered; undecodable instruction entered EX
- fwd_a, fwd_b  out  2 each  operand forwarding selects

Behaviour:
- **Decode (combinational, ID).** ALU codes: add 0, sub 1, and 2, or 3, nor 4, sll 5, srl 6, sra 7, slt 8.
  - R-type (opcode 0): funct 20/21 add, 22/23 sub, 24 and, 25 or, 27 nor, 2A slt, 00 sll, 02 srl, 03 sra. reg_write=1, dest=rd.
  - jr (R-type, funct 08): pcsrc=01, no write.
  - addi (08): add, alu_src=1, dest=rt.
  - lw (23): add, alu_src=1, mem_read=1, memtoreg=1, reg_write=1, dest=rt.
  - sw (2B): add, alu_src=1, mem_write=1.
  - beq (04): sub, pcsrc=10.
  - j (02): pcsrc=11.
  - Any other opcode/funct: all-zero control word with illegal bit set.
- **Destination rule.** The destination is resolved in ID. reg_write is forced to 0 when dest==0.
- **ID/EX register.**
  - Loads the decode output each cycle.
  - Loads an all-zero bubble (illegal=0) when stall=1 or br_taken=1.
- **EX/MEM and MEM/WB.** Always advance; never stalled.
- **Latency.** Control for an instruction appears at ex_* one cycle after ID, mem_* two cycles after, wb_* three cycles after.
- **Load-use hazard.** Condition: ID/EX mem_read=1 and ID/EX dest is non-zero and equals id_rs or id_rt. Response: stall=1, pc_write=0, ifid_write=0.
- **Flush.** br_taken=1 gives ifid_flush=1 and an ID/EX bubble. br_taken overrides stall: stall=0, pc_write=1, ifid_write=1.
- **Reset.**
  - All pipeline registers clear to zero, so every registered output is 0.
  - pc_write=1 and ifid_write=1, because no hazard is possible.
  - Reset mid-stall discards the stalled instruction's bubble and restarts clean.
- **Address widths.** Address compares use the full RA_W.

Optional Feature:
- Macro: PIPE_CTRL_FWD_EN.
- **Defined:**
  - fwd_a/fwd_b = 10 when EX/MEM reg_write=1 and its dest equals ex_rs/ex_rt.
  - Otherwise 01 when MEM/WB reg_write=1 and dest matches.
  - Otherwise 00. EX/MEM has priority over MEM/WB.
  - Only the load-use hazard stalls.
- **Undefined:**
  - fwd_a/fwd_b are tied to 00.
  - Full interlock: stall additionally asserts when id_rs/id_rt (non-zero) matches a reg_write dest in ID/EX or EX/MEM.
  - MEM/WB is not checked, because the register file writes in the first half-cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - ALU opcode constants;
  - opcode/funct constants;
  - PCSRC encodings;
  - FWD select encodings;
  - a packed control-word struct (alu_op, alu_src, pcsrc, mem_read, mem_write, reg_write, memtoreg, dest, illegal).
- The combinational decoder is one natural sub-module, pipe_ctrl_decode, instantiated in ID.
- The hazard/forwarding logic stays in the top module.

Test Plan:
- Reset asserted mid-run → all registered outputs are 0, pc_write=1. After release, add $3,$1,$2 gives ex_alu_op=0 next cycle and wb_reg_write=1, wb_dest=3 three cycles after.
- lw $5,0($1) then add $6,$5,$2 → one cycle with stall=1, pc_write=0, ifid_write=0. A bubble reaches EX (ex_alu_op=0, reg_write=0). The add proceeds the following cycle.
- beq resolved with br_taken=1 in the same cycle as a load-use stall → stall=0, pc_write=1, ifid_flush=1, ID/EX bubble.
- opcode 3F → ex control all zero and illegal=1 for one cycle. addi with rt=0 → wb_reg_write=0.
- FWD_EN defined: add $4,$1,$2 then sub $7,$4,$4 → fwd_a=fwd_b=10, no stall. FWD_EN undefined, same sequence → stall=1 for two cycles, fwd=00.
- FWD_EN defined: add $4 twice back-to-back then or $8,$4,$0 → fwd_a=10 (EX/MEM priority over MEM/WB).
